// File: rtl/dct_pkg.sv
// Shared definitions for the 2-D DCT/IDCT transpose sequencer: FSM states,
// default geometry and stage tags carried alongside every core vector.
package dct_pkg;

  localparam int DEF_D_WIDTH = 13;
  localparam int DEF_N_LOG2  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW   = 3'd1,
    DRAIN = 3'd2,
    COL   = 3'd3,
    WAIT  = 3'd4
  } state_e;

  localparam logic STAGE_ROW = 1'b0;
  localparam logic STAGE_COL = 1'b1;

  // Slots per vector (each sample is presented twice) and samples per block.
  function automatic int vec_slots(input int n_log2);
    return 2 << n_log2;
  endfunction

  function automatic int blk_elems(input int n_log2);
    return 1 << (2 * n_log2);
  endfunction

endpackage

// File: rtl/dct_xpose_ctrl_if.sv
// Bundle of ingress, transpose RAM, 1-D core and output signals around the
// sequencer. The master side is the controller; slave is its environment.
//
// Handshake: ingress transfers on a rising clock edge where in_valid and
// in_ready are both high; in_data must be stable while in_valid is high.
// All other strobes (ram_we, core_en, core_out_en, out_en, done) are
// single-cycle qualifiers with no back-pressure.
interface dct_xpose_ctrl_if #(
    parameter int D_WIDTH = dct_pkg::DEF_D_WIDTH,
    parameter int N_LOG2  = dct_pkg::DEF_N_LOG2
) ();
    import dct_pkg::*;

    logic                  dct_flag;
    logic                  in_valid;
    logic                  in_ready;
    logic [D_WIDTH-1:0]    in_data;
    logic                  ram_we;
    logic [2*N_LOG2-1:0]   ram_waddr;
    logic [2*N_LOG2-1:0]   ram_raddr;
    logic [D_WIDTH-1:0]    ram_rdata;
    logic [D_WIDTH-1:0]    core_data;
    logic                  core_en;
    logic [N_LOG2:0]       core_idx;
    logic                  core_stage;
    logic                  core_out_en;
    logic                  core_out_stage;
    logic [N_LOG2-1:0]     core_out_idx;
    logic                  out_en;
    logic [2*N_LOG2-1:0]   out_idx;
    logic                  busy;
    logic                  done;
    state_e                dbg_state;

    modport master (
        input  dct_flag, in_valid, in_data, ram_rdata,
               core_out_en, core_out_stage, core_out_idx,
        output in_ready, ram_we, ram_waddr, ram_raddr,
               core_data, core_en, core_idx, core_stage,
               out_en, out_idx, busy, done, dbg_state
    );

    modport slave (
        output dct_flag, in_valid, in_data, ram_rdata,
               core_out_en, core_out_stage, core_out_idx,
        input  in_ready, ram_we, ram_waddr, ram_raddr,
               core_data, core_en, core_idx, core_stage,
               out_en, out_idx, busy, done, dbg_state
    );

endinterface

// File: rtl/dct_rd_order.sv
// Column-pass element read order: natural for IDCT, butterfly pairing
// (0, N-1, 1, N-2, ...) for the forward DCT.
module dct_rd_order #(
    parameter int N_LOG2 = 3
) (
    input  logic              mode,
    input  logic [N_LOG2-1:0] k,
    output logic [N_LOG2-1:0] idx
);

    logic [N_LOG2-1:0] half;

    // For odd k, N-1-(k-1)/2 is the bitwise complement of k>>1.
    assign half = {1'b0, k[N_LOG2-1:1]};
    assign idx  = !mode ? k : (k[0] ? ~half : half);

endmodule

// File: rtl/dct_xpose_ctrl.sv
// 2-D DCT/IDCT sequencer: row pass from ingress into the shared 1-D core,
// row results into the transpose RAM, column pass read back column-wise.
module dct_xpose_ctrl
  import dct_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int N_LOG2  = DEF_N_LOG2
) (
    input  logic           clock,
    input  logic           reset,
    dct_xpose_ctrl_if.master bus
);

    localparam int SW = N_LOG2 + 1;        // slot index width
    localparam int CW = 2 * N_LOG2 + 1;    // block counter width
    localparam logic [SW-1:0]     SLOT_LAST = SW'(vec_slots(N_LOG2) - 1);
    localparam logic [N_LOG2-1:0] ROW_LAST  = '1;
    localparam logic [CW-1:0]     BLK_CNT   = CW'(blk_elems(N_LOG2));
    localparam logic [CW-1:0]     RD_LAST   = '1;

    state_e              state_q, state_d;
    logic                mode_q, rdy_q, done_q;
    logic [SW-1:0]       slot_q;
    logic [N_LOG2-1:0]   row_q;
    logic [CW-1:0]       wb_cnt_q, rd_cnt_q, res_cnt_q;
    logic [N_LOG2-1:0]   vec_q;
    logic                rd_v1_q;
    logic [SW-1:0]       rd_idx1_q;
    logic [N_LOG2-1:0]   rd_col1_q;
    logic                core_en_q, core_stage_q;
    logic [SW-1:0]       core_idx_q;
    logic [D_WIDTH-1:0]  core_data_q;

    logic                in_ready, accept, wb_ev, res_ev, res_last, row_last;
    logic [N_LOG2-1:0]   rd_ord, rd_col;

    // rdy_q keeps in_ready low while reset is held; done_q holds it low one more cycle.
    assign in_ready = rdy_q & ~done_q & ((state_q == IDLE) | (state_q == ROW));
    assign accept   = bus.in_valid & in_ready;
    assign row_last = accept & (slot_q == SLOT_LAST) & (row_q == ROW_LAST);
    assign wb_ev    = bus.core_out_en & (bus.core_out_stage == STAGE_ROW) &
                      ((state_q == ROW) | (state_q == DRAIN));
    assign res_ev   = bus.core_out_en & (bus.core_out_stage == STAGE_COL) &
                      ((state_q == COL) | (state_q == WAIT));
    assign res_last = res_ev & (state_q == WAIT) & (res_cnt_q == BLK_CNT - CW'(1));
    assign rd_col   = rd_cnt_q[CW-1:SW];

    dct_rd_order #(.N_LOG2(N_LOG2)) u_rd_order (
        .mode (mode_q),
        .k    (rd_cnt_q[SW-1:1]),
        .idx  (rd_ord)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ROW;
            ROW:     if (row_last) state_d = DRAIN;
            DRAIN:   if (wb_cnt_q == BLK_CNT) state_d = COL;
            COL:     if (rd_cnt_q == RD_LAST) state_d = WAIT;
            WAIT:    if (res_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q       <= 1'b0;
            rdy_q        <= 1'b0;
            done_q       <= 1'b0;
            slot_q       <= '0;
            row_q        <= '0;
            wb_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            res_cnt_q    <= '0;
            vec_q        <= '0;
            rd_v1_q      <= 1'b0;
            rd_idx1_q    <= '0;
            rd_col1_q    <= '0;
            core_en_q    <= 1'b0;
            core_stage_q <= STAGE_ROW;
            core_idx_q   <= '0;
            core_data_q  <= '0;
        end else begin
            rdy_q  <= 1'b1;
            done_q <= res_last;
            if (accept && state_q == IDLE) mode_q <= bus.dct_flag;

            if (accept) begin
                if (slot_q == SLOT_LAST) begin
                    slot_q <= '0;
                    row_q  <= (row_q == ROW_LAST) ? '0 : row_q + N_LOG2'(1);
                end else begin
                    slot_q <= slot_q + SW'(1);
                end
            end

            if (state_q == DRAIN && state_d == COL) wb_cnt_q <= '0;
            else if (wb_ev)                         wb_cnt_q <= wb_cnt_q + CW'(1);

            if (state_q == COL) rd_cnt_q <= (rd_cnt_q == RD_LAST) ? '0 : rd_cnt_q + CW'(1);

            if (res_last)    res_cnt_q <= '0;
            else if (res_ev) res_cnt_q <= res_cnt_q + CW'(1);

            // RAM read pipeline: address in t, data in t+1, core strobe in t+2.
            rd_v1_q   <= (state_q == COL);
            rd_idx1_q <= rd_cnt_q[SW-1:0];
            rd_col1_q <= rd_col;

            core_en_q    <= accept | rd_v1_q;
            core_stage_q <= rd_v1_q ? STAGE_COL : STAGE_ROW;
            if (accept) begin
                core_data_q <= bus.in_data;
                core_idx_q  <= slot_q;
            end else if (rd_v1_q) begin
                core_data_q <= bus.ram_rdata;
                core_idx_q  <= rd_idx1_q;
            end

            // Results of a vector arrive within 2N cycles of its last slot, so one tag suffices.
            if (accept && slot_q == SLOT_LAST)             vec_q <= row_q;
            else if (rd_v1_q && rd_idx1_q == SLOT_LAST)    vec_q <= rd_col1_q;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.ram_we     = wb_ev;
    assign bus.ram_waddr  = wb_ev ? {vec_q, bus.core_out_idx} : '0;
    assign bus.ram_raddr  = (state_q == COL) ? {rd_ord, rd_col} : '0;
    assign bus.core_data  = core_data_q;
    assign bus.core_en    = core_en_q;
    assign bus.core_idx   = core_idx_q;
    assign bus.core_stage = core_stage_q;
    assign bus.out_en     = res_ev;
    assign bus.out_idx    = res_ev ? {bus.core_out_idx, vec_q} : '0;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.dbg_state  = state_q;

endmodule
